// File: rtl/npu_pkg.sv
// Shared NPU definitions for the DSP lane arbiter: lane geometry of the
// multiplier pool and the arbiter FSM state encoding.
package npu_pkg;

    localparam int DSP_DATA_W    = 18;
    localparam int DSP_OUT_W     = 37;
    localparam int NUM_DSP_LANES = 5;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/dsp_lane_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Chooses the first active request
// after i_last_owner (wrapping), so the previous owner always ranks last.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_owner,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int unsigned w_pos;
    logic        w_found;

    // Scan N positions starting one past the last owner; first hit wins.
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_pos    = 0;
        for (int k = 1; k <= N; k++) begin
            w_pos = (32'(i_last_owner) + 32'(k)) % 32'(N);
            if (!w_found && i_req[IW'(w_pos)]) begin
                o_onehot[IW'(w_pos)] = 1'b1;
                o_idx                = IW'(w_pos);
                w_found              = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/dsp_lane_arbiter.sv
// dsp_lane_arbiter: shares the DSP multiplier lane pool between NUM_REQ
// requesters with a locked round-robin grant. The owner's operands are
// registered onto the DSP inputs; products return to everyone with a one-hot
// rsp_valid tag aligned to DSP_LAT.
// Optional feature macro: DSP_ARB_STATS_EN adds stat_clr/stat_busy/stat_wait.
module dsp_lane_arbiter
    import npu_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LANES = NUM_DSP_LANES,
    parameter int DATA_W    = DSP_DATA_W,
    parameter int OUT_W     = DSP_OUT_W,
    parameter int DSP_LAT   = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  req_ce,
    input  logic [NUM_REQ*NUM_LANES*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*NUM_LANES*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_LANES*DATA_W-1:0]         dsp_a,
    output logic [NUM_LANES*DATA_W-1:0]         dsp_b,
    output logic                                dsp_ce,
    input  logic [NUM_LANES*OUT_W-1:0]          dsp_out,
    output logic [NUM_LANES*OUT_W-1:0]          rsp_data,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic                                busy
`ifdef DSP_ARB_STATS_EN
    ,
    input  logic                                stat_clr,
    output logic [31:0]                         stat_busy,
    output logic [31:0]                         stat_wait
`endif
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int SLICE_W = NUM_LANES * DATA_W;
    localparam int CNT_W   = $clog2(DSP_LAT + 2);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;   // current owner, or last owner when idle
    logic [CNT_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
    logic [SLICE_W-1:0] r_dsp_a, r_dsp_b, w_dsp_a_nxt, w_dsp_b_nxt;
    logic               r_dsp_ce, w_dsp_ce_nxt;
    logic [NUM_REQ-1:0] r_tag [DSP_LAT+1];

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [SLICE_W-1:0] w_slice_a [NUM_REQ];
    logic [SLICE_W-1:0] w_slice_b [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice_a[g] = req_a[g*SLICE_W +: SLICE_W];
        assign w_slice_b[g] = req_b[g*SLICE_W +: SLICE_W];
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .i_req        (req),
        .i_last_owner (r_owner),
        .o_onehot     (w_pick_onehot),
        .o_idx        (w_pick_idx),
        .o_any        (w_pick_any)
    );

    // Next-state and registered-output logic of the IDLE/OWN/DRAIN FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_owner_nxt     = r_owner;
        w_drain_cnt_nxt = r_drain_cnt;
        w_dsp_a_nxt     = r_dsp_a;
        w_dsp_b_nxt     = r_dsp_b;
        w_dsp_ce_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = OWN;
                end
            end
            OWN: begin
                if (req[r_owner]) begin
                    w_dsp_a_nxt  = w_slice_a[r_owner];
                    w_dsp_b_nxt  = w_slice_b[r_owner];
                    w_dsp_ce_nxt = req_ce[r_owner];
                end else begin
                    // Release: an operand presented with the dropping req is not issued.
                    w_gnt_nxt       = '0;
                    w_dsp_a_nxt     = '0;
                    w_dsp_b_nxt     = '0;
                    w_drain_cnt_nxt = '0;
                    w_state_nxt     = DRAIN;
                end
            end
            DRAIN: begin
                // Stay DSP_LAT+1 cycles so every in-flight product is tagged out.
                if (r_drain_cnt == CNT_W'(DSP_LAT)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, grant, owner pointer and DSP input registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_drain_cnt <= '0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_dsp_ce    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_dsp_a     <= w_dsp_a_nxt;
            r_dsp_b     <= w_dsp_b_nxt;
            r_dsp_ce    <= w_dsp_ce_nxt;
        end
    end

    // One-hot owner tag follows each issued operand through the DSP pipeline.
    // NOTE: this small pipeline is reset, unlike a data memory, so a reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= DSP_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= r_gnt & req_ce & req;
            for (int i = 1; i <= DSP_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

`ifdef DSP_ARB_STATS_EN
    logic [31:0] r_stat_busy, r_stat_wait;

    // Saturating activity counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_busy <= '0;
            r_stat_wait <= '0;
        end else if (stat_clr) begin
            r_stat_busy <= '0;
            r_stat_wait <= '0;
        end else begin
            if (r_dsp_ce && (r_stat_busy != '1)) r_stat_busy <= r_stat_busy + 1'b1;
            if ((|(req & ~r_gnt)) && (r_stat_wait != '1)) r_stat_wait <= r_stat_wait + 1'b1;
        end
    end

    assign stat_busy = r_stat_busy;
    assign stat_wait = r_stat_wait;
`endif

    assign gnt       = r_gnt;
    assign dsp_a     = r_dsp_a;
    assign dsp_b     = r_dsp_b;
    assign dsp_ce    = r_dsp_ce;
    assign rsp_data  = dsp_out;
    assign rsp_valid = r_tag[DSP_LAT];
    assign busy      = (r_state != IDLE);

    // The grant must never name more than one requester.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));

endmodule

// File: tb/tb_dsp_lane_arbiter.sv
// Scoreboard bench for dsp_lane_arbiter: directed bursts push expected
// responses; a negedge monitor pops and compares whenever rsp_valid is set.
// Stats checks are compiled in when DSP_ARB_STATS_EN is defined.
module tb_dsp_lane_arbiter;
    import npu_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int NUM_LANES = NUM_DSP_LANES;
    localparam int DATA_W    = DSP_DATA_W;
    localparam int OUT_W     = DSP_OUT_W;
    localparam int DSP_LAT   = 1;
    localparam int SLICE_W   = NUM_LANES * DATA_W;
    localparam int RSP_W     = NUM_LANES * OUT_W;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b1;
    logic [NUM_REQ-1:0]           req = '0;
    logic [NUM_REQ-1:0]           req_ce = '0;
    logic [NUM_REQ*SLICE_W-1:0]   req_a = '0;
    logic [NUM_REQ*SLICE_W-1:0]   req_b = '0;
    logic [NUM_REQ-1:0]           gnt;
    logic [SLICE_W-1:0]           dsp_a, dsp_b;
    logic                         dsp_ce;
    logic [RSP_W-1:0]             dsp_out;
    logic [RSP_W-1:0]             rsp_data;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic                         busy;
`ifdef DSP_ARB_STATS_EN
    logic                         stat_clr = 1'b0;
    logic [31:0]                  stat_busy, stat_wait;
`endif

    typedef struct {
        logic [NUM_REQ-1:0] who;
        logic [RSP_W-1:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   dsp_ce_cnt = 0;
    int   bad_op_cnt = 0;
    int   rsp_cnt [NUM_REQ] = '{default: 0};

    dsp_lane_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .OUT_W     (OUT_W),
        .DSP_LAT   (DSP_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_ce    (req_ce),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_ce    (dsp_ce),
        .dsp_out   (dsp_out),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .busy      (busy)
`ifdef DSP_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_busy (stat_busy),
        .stat_wait (stat_wait)
`endif
    );

    always #5 clk = ~clk;

    // DSP lane model: unsigned multiply, DSP_LAT registered stages, loaded on dsp_ce.
    logic [RSP_W-1:0] dsp_pipe [DSP_LAT];
    always @(posedge clk) begin
        if (dsp_ce) begin
            for (int l = 0; l < NUM_LANES; l++)
                dsp_pipe[0][l*OUT_W +: OUT_W] <= OUT_W'(dsp_a[l*DATA_W +: DATA_W]) * OUT_W'(dsp_b[l*DATA_W +: DATA_W]);
        end
        for (int i = 1; i < DSP_LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
    assign dsp_out = dsp_pipe[DSP_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rsp_valid cycle must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid != '0) begin
            for (int r = 0; r < NUM_REQ; r++) if (rsp_valid[r]) rsp_cnt[r]++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b, expected no response", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(e.who));
                n_checks++;
                if (rsp_data !== e.data) begin
                    n_errors++;
                    $display("FAIL rsp_data: got 0x%0h, expected 0x%0h", rsp_data, e.data);
                end
            end
        end
    end

    // Activity watchers: dsp_ce pulses and any forbidden operand on the DSP inputs.
    always @(negedge clk) begin
        if (dsp_ce) dsp_ce_cnt++;
        for (int l = 0; l < NUM_LANES; l++)
            if (dsp_a[l*DATA_W +: DATA_W] == 18'h3FFFF || dsp_b[l*DATA_W +: DATA_W] == 18'h3FFFF)
                bad_op_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive requester r's operands: lane l gets a=av(+l if vary), b=bv; returns expected products.
    task automatic set_ops(input int r, input int av, input int bv, input bit vary, output logic [RSP_W-1:0] e);
        int a_l;
        e = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            a_l = vary ? av + l : av;
            req_a[(r*NUM_LANES+l)*DATA_W +: DATA_W] = DATA_W'(a_l);
            req_b[(r*NUM_LANES+l)*DATA_W +: DATA_W] = DATA_W'(bv);
            e[l*OUT_W +: OUT_W] = OUT_W'(a_l * bv);
        end
    endtask

    task automatic expect_rsp(input int r, input logic [RSP_W-1:0] d);
        exp_t x;
        x.who  = NUM_REQ'(1) << r;
        x.data = d;
        exp_q.push_back(x);
    endtask

    // Owner r holds gnt now: issue n operand sets, then drop req with req_ce still high.
    task automatic burst(input int r, input int n, input int av, input int bv, input bit vary, input bit timing);
        logic [RSP_W-1:0] e;
        for (int k = 0; k < n; k++) begin
            req_ce[r] = 1'b1;
            set_ops(r, vary ? av + k : av, bv, vary, e);
            expect_rsp(r, e);
            if (timing) begin
                if (k == 1) check("burst_dsp_ce_latency", 64'(dsp_ce), 64'd1);
                if (k == DSP_LAT) check("burst_rsp_not_early", 64'(rsp_valid), 64'd0);
                if (k == DSP_LAT + 1) check("burst_rsp_latency", 64'(rsp_valid), 64'(NUM_REQ'(1) << r));
            end
            tick();
        end
        req[r]    = 1'b0;
        req_ce[r] = 1'b1;
        set_ops(r, 7, 7, 1'b0, e);
        tick();
        req_ce[r] = 1'b0;
        check("drop_not_issued", 64'(dsp_ce), 64'd0);
        check("drop_gnt_clear", 64'(gnt), 64'd0);
    endtask

    task automatic wait_gnt(input int r, input int max_cyc, output int cyc);
        cyc = 0;
        while (gnt[r] !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        if (gnt[r] !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL gnt_timeout: got gnt=%b after %0d cycles, expected gnt[%0d]", gnt, cyc, r);
        end
    endtask

    initial begin : stimulus
        int               cyc;
        int               ce0, rsp0, preempt;
        logic [RSP_W-1:0] e;

        // Reset values.
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_dsp_ab", 64'(dsp_a != '0 || dsp_b != '0), 64'd0);
        check("rst_dsp_ce", 64'(dsp_ce), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single requester, 16 operands of 3x4.
        ce0  = dsp_ce_cnt;
        rsp0 = rsp_cnt[0];
        req[0] = 1'b1;
        check("t1_gnt_before", 64'(gnt), 64'd0);
        tick();
        check("t1_gnt", 64'(gnt), 64'b0001);
        check("t1_busy", 64'(busy), 64'd1);
        burst(0, 16, 3, 4, 1'b0, 1'b1);
        repeat (DSP_LAT + 3) tick();
        check("t1_dsp_ce_pulses", 64'(dsp_ce_cnt - ce0), 64'd16);
        check("t1_rsp_pulses", 64'(rsp_cnt[0] - rsp0), 64'd16);
        check("t1_idle", 64'(busy), 64'd0);

        // req[1] and req[2] from reset; non-owners present 0x3FFFF with req_ce.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req[1] = 1'b1;
        req[2] = 1'b1;
        req_ce[2] = 1'b1;
        req_ce[3] = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
            req_a[(2*NUM_LANES+l)*DATA_W +: DATA_W] = 18'h3FFFF;
            req_b[(2*NUM_LANES+l)*DATA_W +: DATA_W] = 18'h3FFFF;
            req_a[(3*NUM_LANES+l)*DATA_W +: DATA_W] = 18'h3FFFF;
            req_b[(3*NUM_LANES+l)*DATA_W +: DATA_W] = 18'h3FFFF;
        end
        tick();
        check("t2_gnt_first", 64'(gnt), 64'b0010);
        burst(1, 4, 100, 3, 1'b1, 1'b0);
        req_ce[2] = 1'b0;
        req_ce[3] = 1'b0;
        wait_gnt(2, 20, cyc);
        check("t2_grant_gap", 64'(cyc + 1), 64'(DSP_LAT + 3));
        check("t2_gnt_second", 64'(gnt), 64'b0100);
        burst(2, 3, 200, 5, 1'b1, 1'b0);
        repeat (DSP_LAT + 3) tick();

        // req[0] owns while req[3] waits 50 cycles.
        req[0] = 1'b1;
        tick();
        check("t3_gnt_owner", 64'(gnt), 64'b0001);
`ifdef DSP_ARB_STATS_EN
        stat_clr = 1'b1;
`endif
        tick();
`ifdef DSP_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        req[3] = 1'b1;
        preempt = 0;
        for (int i = 0; i < 50; i++) begin
            if (gnt !== 4'b0001) preempt++;
            if (i % 2 == 0) begin
                req_ce[0] = 1'b1;
                set_ops(0, 20 + i, 3, 1'b1, e);
                expect_rsp(0, e);
            end else begin
                req_ce[0] = 1'b0;
            end
            tick();
        end
        check("t3_no_preempt", 64'(preempt), 64'd0);
`ifdef DSP_ARB_STATS_EN
        check("t3_stat_wait", 64'(stat_wait), 64'd50);
`endif
        req[0]    = 1'b0;
        req_ce[0] = 1'b0;
        tick();
        req[0] = 1'b1;   // previous owner re-requests during drain: ranks last
        wait_gnt(3, 20, cyc);
        check("t3_gnt_waiter", 64'(gnt), 64'b1000);
        check("t3_waiter_gap", 64'(cyc + 1), 64'(DSP_LAT + 3));
        burst(3, 2, 40, 2, 1'b1, 1'b0);
        wait_gnt(0, 20, cyc);
        check("t3_gnt_back", 64'(gnt), 64'b0001);
        req[0] = 1'b0;
        repeat (DSP_LAT + 4) tick();

`ifdef DSP_ARB_STATS_EN
        // stat_busy saturation and clear-wins-over-increment.
        req[0] = 1'b1;
        wait_gnt(0, 10, cyc);
        force dut.r_stat_busy = 32'hFFFF_FFFD;
        #1;
        release dut.r_stat_busy;
        for (int k = 0; k < 4; k++) begin
            req_ce[0] = 1'b1;
            set_ops(0, 6, 7, 1'b0, e);
            expect_rsp(0, e);
            tick();
        end
        check("t5_busy_saturate", 64'(stat_busy), 64'hFFFF_FFFF);
        check("t5_ce_with_clr", 64'(dsp_ce), 64'd1);
        set_ops(0, 6, 7, 1'b0, e);
        expect_rsp(0, e);
        stat_clr = 1'b1;
        tick();
        stat_clr  = 1'b0;
        req_ce[0] = 1'b0;
        req[0]    = 1'b0;
        check("t5_clr_wins", 64'(stat_busy), 64'd0);
        repeat (DSP_LAT + 4) tick();
`endif

        // Reset two cycles into a burst owned by requester 3.
        req[3]    = 1'b1;
        req_ce[3] = 1'b1;
        set_ops(3, 9, 9, 1'b0, e);
        tick();
        check("t4_gnt_owner", 64'(gnt), 64'b1000);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t4_rst_gnt", 64'(gnt), 64'd0);
        check("t4_rst_dsp_ab", 64'(dsp_a != '0 || dsp_b != '0), 64'd0);
        check("t4_rst_dsp_ce", 64'(dsp_ce), 64'd0);
        check("t4_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        req    = '0;
        req_ce = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        req[0] = 1'b1;
        req[1] = 1'b1;
        tick();
        check("t4_ptr_reset", 64'(gnt), 64'b0010);
        req = '0;
        repeat (DSP_LAT + 4) tick();

        check("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("end_no_bad_operand", 64'(bad_op_cnt), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
